// File: rtl/serial_addsub_seq_pkg.sv
// Shared definitions for the bit-serial add/subtract sequencer.
//   state_t   : sequencer states (IDLE, RUN, DONE)
//   DEF_WIDTH : default operand/result width
//   OP_ADD / OP_SUB : encodings of the 'sub' op select
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int   DEF_WIDTH = 8;
    localparam logic OP_ADD    = 1'b0;
    localparam logic OP_SUB    = 1'b1;

endpackage

// File: rtl/serial_addsub_seq_if.sv
// Handshake/operand bundle between a requester and the serial add/sub sequencer.
//   start, sub, a, b                   : request side (driven by master)
//   ready, busy, done, result, cout,
//   overflow                           : status/result side (driven by slave)
interface serial_addsub_seq_if #(
    parameter int WIDTH = addsub_pkg::DEF_WIDTH
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;

    modport master (
        output start, sub, a, b,
        input  ready, busy, done, result, cout, overflow
    );

    modport slave (
        input  start, sub, a, b,
        output ready, busy, done, result, cout, overflow
    );
endinterface

// File: rtl/full_adder.sv
// One-bit full adder.
//   a, b : addend bits
//   c    : carry in
//   s    : sum bit
//   cr   : carry out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic cr
);
    assign s  = a ^ b ^ c;
    assign cr = (a & b) | (c & (a ^ b));
endmodule

// File: rtl/serial_addsub_seq.sv
// Bit-serial two's-complement add/subtract sequencer. Captures two operands
// and an op select on a start/ready handshake, then feeds one full_adder one
// bit per clock (LSB first), rippling the carry through a register. The
// result, carry-out and signed overflow are held from done until the next
// accepted start.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of serial_addsub_seq_if
//             start/sub/a/b in; ready (IDLE), busy (RUN), done (1-cycle pulse),
//             result, cout (sub: 1 = no borrow), overflow (signed) out
module serial_addsub_seq
    import addsub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_addsub_seq_if.slave  bus
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             carry;
    logic [CNT_W-1:0] idx;
    logic [WIDTH-1:0] result_q;
    logic             cout_q;
    logic             overflow_q;

    logic             accept;
    logic             last_bit;
    logic             fa_s;
    logic             fa_cr;

    assign accept   = (state == IDLE) && bus.start;
    assign last_bit = (idx == LAST_IDX);

    full_adder u_fa (
        .a  (opa[idx]),
        .b  (opb[idx]),
        .c  (carry),
        .s  (fa_s),
        .cr (fa_cr)
    );

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    // NOTE: the default assignment up front keeps this block free of latches.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last_bit)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from the state register only.
    always_comb begin
        bus.ready = (state == IDLE);
        bus.busy  = (state == RUN);
        bus.done  = (state == DONE);
    end

    assign bus.result   = result_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = overflow_q;

    // Datapath. Subtraction is a + ~b + 1, so the inverted operand and an
    // initial carry of 1 are set up at capture time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa        <= '0;
            opb        <= '0;
            carry      <= 1'b0;
            idx        <= '0;
            result_q   <= '0;
            cout_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else if (accept) begin
            opa      <= bus.a;
            opb      <= (bus.sub == OP_SUB) ? ~bus.b : bus.b;
            carry    <= bus.sub;
            idx      <= '0;
            result_q <= '0;
        end else if (state == RUN) begin
            result_q[idx] <= fa_s;
            carry         <= fa_cr;
            if (last_bit) begin
                cout_q     <= fa_cr;
                // carry still holds the carry into the MSB here.
                overflow_q <= carry ^ fa_cr;
            end
            idx <= idx + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_serial_addsub_seq.sv
// Self-checking bench for serial_addsub_seq: directed and random operations,
// expectations from a plain-arithmetic model pushed to a scoreboard queue,
// and a negedge monitor that pops and compares on every done pulse.
module tb_serial_addsub_seq;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] result;
        logic         cout;
        logic         overflow;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t sb_q[$];
    logic prev_done;

    serial_addsub_seq_if #(.WIDTH(W)) bus ();

    serial_addsub_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model in integer arithmetic.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        exp_t e;
        int   sa;
        int   sb;
        int   sr;
        int   ur;
        sa = $signed(a);
        sb = $signed(b);
        if (sub) begin
            sr     = sa - sb;
            ur     = int'(a) - int'(b);
            e.cout = (a >= b);
        end else begin
            sr     = sa + sb;
            ur     = int'(a) + int'(b);
            e.cout = (ur > 255);
        end
        e.result   = ur[W-1:0];
        e.overflow = (sr > 127) || (sr < -128);
        return e;
    endfunction

    // Monitor: compares every done pulse against the scoreboard head.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_done = 1'b0;
        end else begin
            if (bus.done) begin
                exp_t e;
                check("done_width", {31'd0, prev_done}, 32'd0);
                check("ready_busy_in_done", {30'd0, bus.ready, bus.busy}, 32'd0);
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: done with no expected op at %0t", $time);
                end else begin
                    e = sb_q.pop_front();
                    check("result",   {24'd0, bus.result},   {24'd0, e.result});
                    check("cout",     {31'd0, bus.cout},     {31'd0, e.cout});
                    check("overflow", {31'd0, bus.overflow}, {31'd0, e.overflow});
                end
            end
            prev_done = bus.done;
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (!bus.ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: ready=%0b required 1", bus.ready);
        end
    endtask

    // Issue one op; optionally pulse a stray start mid-run.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         input bit inject);
        int cnt;
        @(negedge clk);
        wait_ready();
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.sub   = sub;
        @(posedge clk);
        sb_q.push_back(model(a, b, sub));
        #1;
        bus.start = 1'b0;
        // Operand changes after accept must not matter.
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.sub   = 1'($urandom);
        cnt = 0;
        while (cnt < 50) begin
            @(negedge clk);
            if (bus.ready) break;
            cnt++;
            if (inject && cnt == 3) begin
                bus.start = 1'b1;
                bus.a     = 8'h10;
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        check("ready_low_cycles", cnt, 32'd9);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},    {31'd0, bus.ready},    32'd1);
        check({tag, "_busy"},     {31'd0, bus.busy},     32'd0);
        check({tag, "_done"},     {31'd0, bus.done},     32'd0);
        check({tag, "_result"},   {24'd0, bus.result},   32'd0);
        check({tag, "_cout"},     {31'd0, bus.cout},     32'd0);
        check({tag, "_overflow"}, {31'd0, bus.overflow}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        prev_done = 1'b0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        do_op(8'h05, 8'h03, 1'b1, 1'b0);
        do_op(8'h03, 8'h05, 1'b1, 1'b0);
        do_op(8'h7F, 8'h01, 1'b0, 1'b0);
        do_op(8'h80, 8'h01, 1'b1, 1'b0);
        do_op(8'hFF, 8'h01, 1'b0, 1'b0);
        do_op(8'h05, 8'h03, 1'b1, 1'b1);
        do_op(8'h00, 8'h00, 1'b1, 1'b0);
        do_op(8'h80, 8'h80, 1'b0, 1'b0);

        // Abort mid-run: no expectation pushed for the discarded op.
        @(negedge clk);
        wait_ready();
        bus.start = 1'b1;
        bus.a     = 8'h05;
        bus.b     = 8'h03;
        bus.sub   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        check_reset_outputs("abort_hold");
        rst_n = 1'b1;
        do_op(8'h05, 8'h05, 1'b0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
        end

        repeat (3) @(negedge clk);
        check("sb_empty", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_addsub_seq.md
Name: serial_addsub_seq

Overview:
Bit-serial two's-complement add/subtract sequencer that feeds the 1-bit full_adder one bit per clock, LSB first. It captures two operands and an op select through a start/ready handshake, then runs WIDTH cycles, rippling the carry through a register. The final sum, carry-out and signed overflow are held until the next operation. This is the clocked control stage upstream of full_adder; it replaces the hand-sequenced testbench loop with synthesizable RTL.

Parameters:
WIDTH, 8, operand/result width in bits (minimum 2).
CNT_W, $clog2(WIDTH), width of the bit-index counter.

Ports:
clk  input  1  rising-edge clock; the only clock.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  request; sampled only while ready=1.
sub  input  1  0 = a+b, 1 = a-b; captured with start.
a  input  WIDTH  operand A; captured with start.
b  input  WIDTH  operand B; captured with start.
ready  output  1  high in IDLE only.
busy  output  1  high in RUN.
done  output  1  one-cycle pulse when the result becomes valid.
result  output  WIDTH  sum/difference; held from done until the next accepted start.
cout  output  1  final carry-out; for sub, 1 = no borrow (a >= b unsigned).
overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (async assert, sync release): state=IDLE, ready=1, busy=0, done=0, result=0, cout=0, overflow=0, internal op/carry/counter regs=0.
- States: IDLE -> RUN on edge with start=1; RUN -> DONE on edge processing bit WIDTH-1; DONE -> IDLE unconditionally on the next edge.
- Capture at accept edge: opa<=a; opb<=(sub ? ~b : b); carry<=sub; idx<=0; result cleared to 0.
- RUN, each edge: full_adder inputs are opa[idx], opb[idx], carry. Write result[idx]<=s and carry<=cr. On idx=WIDTH-1, also latch cout<=cr and overflow<=carry XOR cr, where carry is the pre-update carry into the MSB. Then idx<=idx+1.
- Latency: start accepted at edge k; bits are processed on edges k+1..k+WIDTH; done=1 during the cycle after edge k+WIDTH; ready returns at edge k+WIDTH+1.
- done is exactly one cycle wide. result, cout and overflow are stable from done until the next accepted start.
- start while busy or done: ignored; no queuing. Changes on a/b/sub after accept have no effect.
- Reset mid-RUN: immediate abort to the reset values; the partial result is discarded.
- idx never wraps past WIDTH-1 in RUN. The counter is CNT_W bits; for WIDTH a power of 2, the wrap to 0 after the last bit is harmless because the state is no longer RUN.
- Combinational paths: none from inputs to outputs. All outputs are registered or decoded from the state register.

Decomposition:
- Package addsub_pkg: state enum {IDLE, RUN, DONE}, default WIDTH constant, OP_ADD=1'b0 / OP_SUB=1'b1 constants.
- Sub-module: one instance of the existing full_adder (ports a, b, c, s, cr), instantiated inside serial_addsub_seq. No other sub-modules.

Test Plan:
- a=8'h05, b=8'h03, sub=1 -> after 8 RUN cycles, done pulse; result=8'h02, cout=1, overflow=0.
- a=8'h03, b=8'h05, sub=1 -> result=8'hFE, cout=0 (borrow), overflow=0.
- a=8'h7F, b=8'h01, sub=0 -> result=8'h80, cout=0, overflow=1. Then a=8'h80, b=8'h01, sub=1 -> result=8'h7F, cout=1, overflow=1.
- a=8'hFF, b=8'h01, sub=0 -> result=8'h00, cout=1, overflow=0. Check done is high exactly 1 cycle and ready is low for 9 cycles.
- Pulse start with a=8'h10 during RUN of 8'h05-8'h03 -> ignored; result=8'h02; next accepted op is unaffected.
- Assert rst_n=0 at RUN bit 4, release, then run 8'h05+8'h05 -> all outputs 0 during reset; next result=8'h0A, cout=0, overflow=0.
